async_count_reader: RTL and testbench
=====================================

# async_count_reader

Synchronous reader for the asynchronous ripple up/down counters. It samples an N-bit count that changes asynchronously to `clk` and filters out ripple glitches. It publishes each stable value, together with the step size and direction-aware wrap indication, into the `clk` domain. It sits between any ripple counter instance and synchronous consumer logic.

## Interface
- `N`, default 3: counter width in bits, N ≥ 2.
- `STABLE`, default 2: consecutive matching synchronized samples required before a value is accepted, STABLE ≥ 1.

- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `count_in`  input  N  raw ripple-counter output, asynchronous to `clk`.
- `sel`  input  1  counting direction of the source: 1 = up, 0 = down. Synchronous to `clk`, sampled at acceptance.
- `count_out`  output  N  last accepted count (registered).
- `valid`  output  1  one-cycle pulse when `count_out` is updated.
- `delta`  output  N  steps moved since the previous accepted value, modulo 2^N (registered).
- `wrap`  output  1  one-cycle pulse, coincident with `valid`, when the move crossed the 0/2^N−1 boundary.

## Operation
- **Synchronizer.** Per-bit 2-flop chain `count_in` → s1 → s2. A third register s3 holds the previous s2.
- **Stability counter `stab`.**
  - Width is clog2(STABLE+1).
  - If s2 == s3, `stab` increments, saturating at STABLE.
  - Otherwise `stab` is cleared to 0.
- **FSM states.**
  - INIT: entered on reset. When `stab` == STABLE, load `count_out` ← s2, pulse `valid`, drive `delta` = 0 and `wrap` = 0, then go to TRACK. This acceptance happens even if s2 == 0.
  - TRACK: accept when `stab` == STABLE and s2 ≠ `count_out`. Otherwise hold all outputs and keep `valid`/`wrap` low.
- **Acceptance arithmetic in TRACK.** Let old = `count_out`, new = s2.
  - `sel` = 1: `delta` = (new − old) mod 2^N; `wrap` = (new < old).
  - `sel` = 0: `delta` = (old − new) mod 2^N; `wrap` = (new > old).
  - Then `count_out` ← new.
- **Output lifetimes.** `delta` holds its value until the next acceptance. `valid` and `wrap` are high for exactly one cycle.
- **Glitch rejection.** Any sample that does not persist for STABLE+1 consecutive s2 values is never published.
- **Direction change.** A change of `sel` between acceptances affects only the next acceptance computation. There is no retroactive correction.
- **Equal values.** A value equal to `count_out` never produces `valid`, so a full 2^N-step lap between acceptances is invisible. This is a documented limitation.

## Timing
- **Reset values.** While `reset` is high at a rising edge, the next state is: s1, s2, s3, `stab` = 0; state = INIT; `count_out` = 0, `delta` = 0, `valid` = 0, `wrap` = 0.
- **Reset priority.** `reset` has priority over everything, including an acceptance in the same cycle.
- **Latency.** Call E0 the edge at which s1 first captures a new `count_in` value. If `count_in` holds, `count_out`, `delta`, `wrap` and `valid` update at edge E0+STABLE+3 (E0+5 with the defaults).
  - E0+1: s2 gets the new value.
  - E0+2: `stab` clears.
  - E0+3 … E0+STABLE+2: `stab` counts up.
  - E0+STABLE+3: update.
- **First publish after reset.** Reset is released at edge R. With `count_in` constant at value V, the first `valid` occurs at edge R+STABLE+3 with `count_out` = V and `delta` = 0.
- **Back-to-back changes.** A new `count_in` change arriving before acceptance restarts the window. The earliest next `valid` is STABLE+3 edges after the latest change.
- **Minimum spacing.** Two consecutive `valid` pulses are at least STABLE+1 cycles apart.

## Test plan
Default parameters (N = 3, STABLE = 2) unless stated.
1. **Reset.** `reset` high for 2 cycles with `count_in` = 3 → all outputs 0 during reset. After release, `valid` fires once at R+5 with `count_out` = 3, `delta` = 0, `wrap` = 0.
2. **Single step up.** From `count_out` = 3, `sel` = 1, `count_in` → 4 → exactly one `valid` at E0+5 with `count_out` = 4, `delta` = 1, `wrap` = 0.
3. **Wrap up.** From 7, `sel` = 1, `count_in` → 1 → `delta` = 2 and `wrap` = 1 on the same cycle as `valid`.
4. **Wrap down.** From 2, `sel` = 0, `count_in` → 6 → `delta` = 4, `wrap` = 1. Then `count_in` → 5 → `delta` = 1, `wrap` = 0.
5. **Glitch rejection.** From `count_out` = 3, `count_in` → 5 for 2 cycles, then back to 3 → no `valid`, and `count_out` stays 3. Also drive a ripple sequence 3 → 2 → 0 → 4, each held 1 cycle, with 4 then held → a single `valid` with `delta` = 1 (`sel` = 1).
6. **Reset mid-operation.** Change `count_in` 3 → 4 and assert `reset` at E0+4 → no `valid`, all outputs 0. After release, INIT republishes 4 with `delta` = 0.

Source files
------------

// File: rtl/async_count_reader.sv
// async_count_reader: samples a ripple counter into the clk domain and publishes each stable value with step size and wrap
//
// Ports:
//   i_clk        system clock, rising edge
//   i_reset      synchronous active-high reset
//   i_count_in   raw ripple-counter value, asynchronous to i_clk
//   i_sel        source direction (1 = up, 0 = down), sampled at acceptance
//   o_count_out  last accepted count
//   o_valid      one-cycle pulse when o_count_out updates
//   o_delta      steps moved since previous accepted value, modulo 2^N
//   o_wrap       one-cycle pulse with o_valid when the move crossed the 0/2^N-1 boundary
module async_count_reader #(
    parameter int N      = 3,
    parameter int STABLE = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_count_in,
    input  logic         i_sel,
    output logic [N-1:0] o_count_out,
    output logic         o_valid,
    output logic [N-1:0] o_delta,
    output logic         o_wrap
);
    localparam int SW = $clog2(STABLE + 1);

    typedef enum logic {INIT, TRACK} state_t;

    state_t        r_state, w_next;
    logic [N-1:0]  r_s1, r_s2, r_s3;
    logic [SW-1:0] r_stab;
    logic          w_stable, w_accept, w_wrap;
    logic [N-1:0]  w_delta;

    always_comb begin
        // stab reflects the history up to the previous s2; the s2 == s3 term
        // keeps a freshly changed s2 from riding on a saturated count
        w_stable = (r_stab == SW'(STABLE)) && (r_s2 == r_s3);
        w_next   = r_state;
        w_accept = 1'b0;
        w_delta  = '0;
        w_wrap   = 1'b0;
        if (r_state == INIT) begin
            w_accept = w_stable;
            w_next   = w_stable ? TRACK : INIT;
        end else begin
            w_accept = w_stable && (r_s2 != o_count_out);
            w_delta  = i_sel ? r_s2 - o_count_out : o_count_out - r_s2;
            w_wrap   = i_sel ? (r_s2 < o_count_out) : (r_s2 > o_count_out);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_stab      <= '0;
            r_state     <= INIT;
            o_count_out <= '0;
            o_delta     <= '0;
            o_valid     <= 1'b0;
            o_wrap      <= 1'b0;
        end else begin
            r_s1    <= i_count_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_stab  <= (r_s2 != r_s3) ? '0 : (r_stab == SW'(STABLE)) ? r_stab : r_stab + 1'b1;
            r_state <= w_next;
            o_valid <= w_accept;
            o_wrap  <= w_accept & w_wrap;
            if (w_accept) begin
                o_count_out <= r_s2;
                o_delta     <= w_delta;
            end
        end
    end
endmodule

// File: tb/tb_async_count_reader.sv
// tb_async_count_reader: scoreboard bench for async_count_reader with default parameters
module tb_async_count_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] count_in = 3'd3;
    logic       sel = 1'b1;
    logic [2:0] count_out, delta;
    logic       valid, wrap;
    int         cyc = 0;
    int         passed = 0;
    int         total = 0;

    typedef struct {
        logic [2:0] c;
        logic [2:0] d;
        logic       w;
        int         t;
    } exp_t;

    exp_t sb[$];

    async_count_reader dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_count_in  (count_in),
        .i_sel       (sel),
        .o_count_out (count_out),
        .o_valid     (valid),
        .o_delta     (delta),
        .o_wrap      (wrap)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // advance to the next falling edge and score whatever the DUT published
    task automatic tick();
        exp_t e;
        @(negedge clk);
        total++;
        if (valid) begin
            if (sb.size() == 0) begin
                $display("FAIL unexpected_valid: count_out=%0d delta=%0d wrap=%0b at cycle %0d, required no valid", count_out, delta, wrap, cyc);
            end else begin
                e = sb.pop_front();
                if ({count_out, delta, wrap} !== {e.c, e.d, e.w} || cyc != e.t)
                    $display("FAIL publish: got count_out=%0d delta=%0d wrap=%0b cycle=%0d, required %0d/%0d/%0b cycle=%0d", count_out, delta, wrap, cyc, e.c, e.d, e.w, e.t);
                else
                    passed++;
            end
        end else begin
            if (wrap !== 1'b0)
                $display("FAIL wrap_without_valid: wrap=%0b at cycle %0d, required 0", wrap, cyc);
            else
                passed++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // change the source value now (just after a falling edge) and expect a publish E0+5
    task automatic drive(input logic [2:0] v, input logic [2:0] d, input logic w);
        count_in = v;
        sb.push_back('{c: v, d: d, w: w, t: cyc + 6});
    endtask

    task automatic check_drained(input string name);
        total++;
        if (sb.size() != 0) begin
            $display("FAIL %s_missing_valid: %0d publishes outstanding, required 0", name, sb.size());
            sb.delete();
        end else passed++;
    endtask

    task automatic check_zero(input string name);
        total++;
        if ({count_out, delta, valid, wrap} !== 8'd0)
            $display("FAIL %s_zero: count_out=%0d delta=%0d valid=%0b wrap=%0b, required all 0", name, count_out, delta, valid, wrap);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        count_in = 3'd3;
        tick();
        check_zero("reset_c1");
        tick();
        check_zero("reset_c2");
        reset = 1'b0;
        sb.push_back('{c: 3'd3, d: 3'd0, w: 1'b0, t: cyc + 6});
        ticks(8);
        check_drained("reset");
    endtask

    task automatic test_step_up();
        sel = 1'b1;
        drive(3'd4, 3'd1, 1'b0);
        ticks(8);
        check_drained("step_up");
    endtask

    task automatic test_wrap_up();
        sel = 1'b1;
        drive(3'd7, 3'd3, 1'b0);
        ticks(8);
        drive(3'd1, 3'd2, 1'b1);
        ticks(8);
        check_drained("wrap_up");
    endtask

    task automatic test_wrap_down();
        sel = 1'b1;
        drive(3'd2, 3'd1, 1'b0);
        ticks(8);
        sel = 1'b0;
        drive(3'd6, 3'd4, 1'b1);
        ticks(8);
        drive(3'd5, 3'd1, 1'b0);
        ticks(8);
        drive(3'd3, 3'd2, 1'b0);
        ticks(8);
        check_drained("wrap_down");
    endtask

    task automatic test_glitch();
        sel = 1'b1;
        count_in = 3'd5;
        ticks(2);
        count_in = 3'd3;
        ticks(8);
        check_drained("glitch");
        total++;
        if (count_out !== 3'd3)
            $display("FAIL glitch_hold: count_out=%0d, required 3", count_out);
        else passed++;
        count_in = 3'd2;
        tick();
        count_in = 3'd0;
        tick();
        drive(3'd4, 3'd1, 1'b0);
        ticks(8);
        check_drained("ripple");
    endtask

    task automatic test_reset_mid();
        sel = 1'b1;
        drive(3'd3, 3'd7, 1'b1);
        ticks(8);
        count_in = 3'd4;
        ticks(4);
        reset = 1'b1;
        tick();
        check_zero("mid_c1");
        tick();
        check_zero("mid_c2");
        reset = 1'b0;
        sb.push_back('{c: 3'd4, d: 3'd0, w: 1'b0, t: cyc + 6});
        ticks(8);
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_wrap_up();
        test_wrap_down();
        test_glitch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
